// File: rtl/shift_stack_pkg.sv
// Shared definitions for the shift-stack family (capture logic, buffer, consumer).
//   mode_e     : buffer ordering, LIFO (0) or FIFO (1)
//   entry_op_e : per-entry storage action selected by the buffer control
package shift_stack_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ENTRY_HOLD,
    ENTRY_SHIFT_UP,
    ENTRY_SHIFT_DOWN,
    ENTRY_LOAD_TOP
  } entry_op_e;

endpackage

// File: rtl/shift_stack_buffer.sv
// shift_stack_buffer
//   Parametrised shift-register buffer working as a LIFO or FIFO. Every push
//   shifts the entries up by one and writes the new word at entry 0. LIFO pops
//   read entry 0 and shift the entries down. FIFO pops read the oldest entry at
//   count-1 without shifting.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   mode        : requested ordering, only taken while empty and not pushing
//   push, pop   : operation requests for this cycle
//   din         : write data
//   dout        : registered read data, holds the last popped word
//   dout_valid  : one-cycle pulse after a successful pop
//   full, empty : combinational status from count
//   count       : number of occupied entries
//   overflow    : one-cycle pulse after a dropped push
//   underflow   : one-cycle pulse after a pop on an empty buffer
module shift_stack_buffer
  import shift_stack_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [CNT_W-1:0]              r_count;
  mode_e                         r_modeQ;
  logic [DEPTH-1:0][DATA_W-1:0]  w_mem;
  logic                          w_popOk;
  logic                          w_pushOk;
  logic [CNT_W-1:0]              w_countNext;
  logic [CNT_W-1:0]              w_srcIdx;
  logic [DATA_W-1:0]             w_fifoSrc;
  logic [DATA_W-1:0]             w_popSrc;
  entry_op_e                     w_entryOp;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Decide what this cycle actually does. A push into a full buffer is still
  // accepted when a pop frees a slot on the same edge. The pop source is read
  // from the pre-edge contents, so push+pop returns the old word.
  always_comb begin
    w_popOk     = pop && !empty;
    w_pushOk    = push && (!full || w_popOk);

    w_countNext = r_count;
    if (w_pushOk && !w_popOk) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (!w_pushOk && w_popOk) begin
      w_countNext = r_count - CNT_W'(1);
    end

    // In LIFO, push+pop only replaces the top. In FIFO it shifts din in while
    // the oldest word leaves from the far end.
    w_entryOp = ENTRY_HOLD;
    if (w_pushOk && w_popOk) begin
      w_entryOp = (r_modeQ == MODE_LIFO) ? ENTRY_LOAD_TOP : ENTRY_SHIFT_UP;
    end else if (w_pushOk) begin
      w_entryOp = ENTRY_SHIFT_UP;
    end else if (w_popOk && (r_modeQ == MODE_LIFO)) begin
      w_entryOp = ENTRY_SHIFT_DOWN;
    end

    // The FIFO read index is decoded explicitly so that count-1 never has to
    // index the storage array directly.
    w_srcIdx  = empty ? '0 : (r_count - CNT_W'(1));
    w_fifoSrc = w_mem[0];
    for (int k = 0; k < DEPTH; k++) begin
      if (w_srcIdx == CNT_W'(k)) begin
        w_fifoSrc = w_mem[k];
      end
    end
    w_popSrc = (r_modeQ == MODE_FIFO) ? w_fifoSrc : w_mem[0];
  end

  // One register per entry. Each entry picks its next value from a four-way
  // mux. Entries that fall outside the new count are cleared, so that unused
  // slots stay zero and stale data never appears.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [DATA_W-1:0] r_entry;
    logic [DATA_W-1:0] w_upSrc;
    logic [DATA_W-1:0] w_downSrc;
    logic [DATA_W-1:0] w_next;

    if (i == 0) begin : g_bottom
      assign w_upSrc = din;
    end else begin : g_inner
      assign w_upSrc = w_mem[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign w_downSrc = '0;
    end else begin : g_notLast
      assign w_downSrc = w_mem[i+1];
    end

    always_comb begin
      w_next = r_entry;
      case (w_entryOp)
        ENTRY_SHIFT_UP:   w_next = w_upSrc;
        ENTRY_SHIFT_DOWN: w_next = w_downSrc;
        ENTRY_LOAD_TOP:   w_next = (i == 0) ? din : r_entry;
        default:          w_next = r_entry;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_entry <= '0;
      end else if (CNT_W'(i) < w_countNext) begin
        r_entry <= w_next;
      end else begin
        r_entry <= '0;
      end
    end

    assign w_mem[i] = r_entry;
  end

  // Count, mode latch and the registered read port. The mode can only change
  // while the buffer is empty and nothing is being pushed, so the stored data
  // is always read back in the ordering it was written under.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_modeQ    <= MODE_LIFO;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      if (empty && !push) begin
        r_modeQ <= mode_e'(mode);
      end
      dout_valid <= w_popOk;
      if (w_popOk) begin
        dout <= w_popSrc;
      end
      overflow   <= push && full && !pop;
      underflow  <= pop && empty;
    end
  end

endmodule
